// File: rtl/updown_counter_ctrl_pkg.sv
// Shared types and defaults for the up/down counter sequencer.
package updown_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 9;
  localparam int DEFAULT_DIV   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2,
    HOLD = 2'd3
  } ctrl_state_e;

  // Prescaler needs enough bits to reach DIV-1, never fewer than one.
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/updown_counter_ctrl_if.sv
// Request/feedback bus between front-panel logic, the sequencer and the 9-bit counter.
interface updown_counter_ctrl_if import updown_ctrl_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             stop;
  logic             load_req;
  logic [WIDTH-1:0] load_val;
  logic             dir_req;
  logic [WIDTH-1:0] countout;
  logic [WIDTH-1:0] data;
  logic             endata;
  logic             clken;
  logic             updown;
  logic             busy;
  logic             at_bound;

  modport master (
    output start, stop, load_req, load_val, dir_req, countout,
    input  data, endata, clken, updown, busy, at_bound
  );

  modport slave (
    input  start, stop, load_req, load_val, dir_req, countout,
    output data, endata, clken, updown, busy, at_bound
  );
endinterface

// File: rtl/updown_counter_ctrl_tick_prescaler.sv
// Free-running 0..DIV-1 divider; tc fires one cycle before the terminal count so a
// registered consumer lands its output exactly on the terminal cycle.
module tick_prescaler import updown_ctrl_pkg::*; #(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int PW = presc_width(DIV);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == PW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = enable && !clear && (cnt_q == PW'(DIV - 2));
endmodule

// File: rtl/updown_counter_ctrl.sv
// Sequencer for the up/down counter: tick generation, preset loads, direction and bound handling.
// Define UPDOWN_CTRL_PINGPONG_EN to reverse at a bound instead of halting in HOLD.
module updown_counter_ctrl import updown_ctrl_pkg::*; #(
  parameter int               WIDTH = DEFAULT_WIDTH,
  parameter int               DIV   = DEFAULT_DIV,
  parameter logic [WIDTH-1:0] UPPER = WIDTH'(255),
  parameter logic [WIDTH-1:0] LOWER = '0
) (
  input logic                 clk,
  input logic                 reset,
  updown_counter_ctrl_if.slave bus
);
  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             endata_q, endata_d;
  logic             clken_q, clken_d;
  logic             updown_q, updown_d;
  logic             busy_q, busy_d;
  logic             at_bound_q, at_bound_d;
  logic             from_run_q, from_run_d;
  logic             tick;
  logic             bound_hit;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != RUN),
    .enable (state_q == RUN),
    .tc     (tick)
  );

  // Out-of-range feedback counts as sitting on the bound of the current direction.
  always_comb begin
    bound_hit = ($signed({1'b0, bus.countout}) < $signed({1'b0, LOWER})) ||
                (bus.countout > UPPER) ||
                (updown_q ? (bus.countout >= UPPER) : (bus.countout <= LOWER));
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    updown_d   = updown_q;
    from_run_d = from_run_q;
    clken_d    = 1'b0;
`ifdef UPDOWN_CTRL_PINGPONG_EN
    at_bound_d = 1'b0;
`else
    at_bound_d = at_bound_q;
`endif
    case (state_q)
      IDLE, HOLD: begin
        if (!bus.stop) begin
          if (bus.load_req) begin
            state_d    = LOAD;
            data_d     = bus.load_val;
            from_run_d = 1'b0;
            at_bound_d = 1'b0;
          end else if (bus.start) begin
            state_d    = RUN;
            updown_d   = bus.dir_req;
            at_bound_d = 1'b0;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.load_req) begin
          state_d    = LOAD;
          data_d     = bus.load_val;
          from_run_d = 1'b1;
          at_bound_d = 1'b0;
        end else if (tick) begin
          if (bound_hit) begin
`ifdef UPDOWN_CTRL_PINGPONG_EN
            updown_d   = !updown_q;
            at_bound_d = 1'b1;
`else
            state_d    = HOLD;
            at_bound_d = 1'b1;
`endif
          end else begin
            clken_d = 1'b1;
          end
        end
      end
      LOAD: begin
        // A stop during the load strobe cancels any resume into RUN.
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.load_req) begin
          data_d     = bus.load_val;
          at_bound_d = 1'b0;
        end else begin
          state_d = from_run_q ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    endata_d = (state_d == LOAD);
    busy_d   = (state_d == RUN) || (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      endata_q   <= 1'b0;
      clken_q    <= 1'b0;
      updown_q   <= 1'b1;
      busy_q     <= 1'b0;
      at_bound_q <= 1'b0;
      from_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      endata_q   <= endata_d;
      clken_q    <= clken_d;
      updown_q   <= updown_d;
      busy_q     <= busy_d;
      at_bound_q <= at_bound_d;
      from_run_q <= from_run_d;
    end
  end

  assign bus.data     = data_q;
  assign bus.endata   = endata_q;
  assign bus.clken    = clken_q;
  assign bus.updown   = updown_q;
  assign bus.busy     = busy_q;
  assign bus.at_bound = at_bound_q;
endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Self-checking bench for updown_counter_ctrl: vector table, corner sequences and a
// randomized run compared every cycle against a behavioural model of the sequencer.
module tb_updown_counter_ctrl;
  localparam int WIDTH = 9;
  localparam int DIV   = 10;
  localparam int UPPER = 255;
  localparam int LOWER = 0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  updown_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

  updown_counter_ctrl #(
    .WIDTH (WIDTH),
    .DIV   (DIV),
    .UPPER (9'd255),
    .LOWER (9'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Stand-in for the real 9-bit counter so bound detection sees live feedback.
  logic [8:0] counterQ;
  always @(posedge clk or negedge reset) begin
    if (!reset)           counterQ <= '0;
    else if (bus.endata)  counterQ <= bus.data;
    else if (bus.clken)   counterQ <= bus.updown ? counterQ + 9'd1 : counterQ - 9'd1;
  end
  assign bus.countout = counterQ;

  // Behavioural model: activity flags, cycles elapsed since the tick phase restarted.
  bit         mRunning, mLoading, mHolding, mResume, mUp;
  int         mElapsed;
  logic [8:0] mData;
  bit         eEndata, eClken, eBusy, eAtBound;

  function automatic bit atBound(input int c, input bit up);
    if (c > UPPER || c < LOWER) return 1'b1;
    return up ? (c >= UPPER) : (c <= LOWER);
  endfunction

  task automatic modelReset();
    mRunning = 0; mLoading = 0; mHolding = 0; mResume = 0; mUp = 1;
    mElapsed = 0; mData = '0;
    eEndata = 0; eClken = 0; eBusy = 0; eAtBound = 0;
  endtask

  task automatic modelStep(input bit st, input bit sp, input bit ld, input logic [8:0] val,
                           input bit dir, input int cnt);
    bit wasRun, wasLoad, wasIdleOrHold;
    wasRun        = mRunning;
    wasLoad       = mLoading;
    wasIdleOrHold = !mRunning && !mLoading;
    eClken = 0;
`ifdef UPDOWN_CTRL_PINGPONG_EN
    eAtBound = 0;
`endif
    if (sp) begin
      if (wasRun || wasLoad) begin mRunning = 0; mLoading = 0; end
    end else if (ld) begin
      mResume  = wasRun || (wasLoad && mResume);
      mRunning = 0; mHolding = 0; mLoading = 1;
      mData    = val;
      eAtBound = 0;
    end else if (st && wasIdleOrHold) begin
      mRunning = 1; mHolding = 0; mElapsed = 0; mUp = dir; eAtBound = 0;
    end else if (wasRun) begin
      mElapsed++;
      if (mElapsed % DIV == DIV - 1) begin
        if (atBound(cnt, mUp)) begin
`ifdef UPDOWN_CTRL_PINGPONG_EN
          mUp = !mUp;
`else
          mRunning = 0; mHolding = 1;
`endif
          eAtBound = 1;
        end else begin
          eClken = 1;
        end
      end
    end else if (wasLoad) begin
      mLoading = 0;
      if (mResume) begin mRunning = 1; mElapsed = 0; end
    end
    eEndata = mLoading;
    eBusy   = mRunning || mLoading;
  endtask

  function automatic logic [13:0] outVec();
    return {bus.data, bus.endata, bus.clken, bus.updown, bus.busy, bus.at_bound};
  endfunction

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    checkVal(name, {18'd0, outVec()}, {18'd0, mData, eEndata, eClken, mUp, eBusy, eAtBound});
  endtask

  // One cycle: compare against the model at the falling edge, then drive new requests.
  task automatic applyStimulus(input bit st, input bit sp, input bit ld,
                               input logic [8:0] val, input bit dir);
    @(negedge clk);
    checkOutput("model");
    bus.start = st; bus.stop = sp; bus.load_req = ld; bus.load_val = val; bus.dir_req = dir;
    modelStep(st, sp, ld, val, dir, int'(bus.countout));
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 9'h000, 0);
  endtask

  typedef struct {
    bit         start, stop, load_req;
    logic [8:0] load_val;
    bit         dir_req;
    logic [8:0] expData;
    bit         expEndata, expClken, expUpdown, expBusy, expAtBound;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int found;
    int activity;

    bus.start = 0; bus.stop = 0; bus.load_req = 0; bus.load_val = '0; bus.dir_req = 0;
    modelReset();

    vecs[0]  = '{0, 0, 0, 9'h000, 0, 9'h000, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 1, 0, 9'h000, 0, 9'h000, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 0, 9'h000, 0, 9'h000, 0, 0, 0, 1, 0};
    vecs[3]  = '{1, 0, 0, 9'h000, 1, 9'h000, 0, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 1, 9'h0AA, 0, 9'h0AA, 1, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 9'h000, 0, 9'h0AA, 0, 0, 0, 1, 0};
    vecs[6]  = '{1, 1, 1, 9'h033, 0, 9'h0AA, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 9'h1FF, 0, 9'h1FF, 1, 0, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 9'h000, 0, 9'h1FF, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 9'h000, 1, 9'h1FF, 0, 0, 1, 1, 0};
    vecs[10] = '{0, 1, 0, 9'h000, 0, 9'h1FF, 0, 0, 1, 0, 0};

    // Reset held low for 50 ns, then released.
    #50;
    checkVal("reset_outputs", {18'd0, outVec()}, {18'd0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    reset = 1'b1;
    for (int i = 0; i < 3; i++) idleCycle();
    checkVal("idle_after_reset", {18'd0, outVec()}, {18'd0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].load_req, vecs[i].load_val, vecs[i].dir_req);
      @(posedge clk);
      #1;
      checkVal($sformatf("vec%0d", i), {18'd0, outVec()},
               {18'd0, vecs[i].expData, vecs[i].expEndata, vecs[i].expClken,
                vecs[i].expUpdown, vecs[i].expBusy, vecs[i].expAtBound});
    end
    idleCycle();

    // Preset 0, start counting up: first tick DIV cycles after start, then every DIV.
    applyStimulus(0, 0, 1, 9'h000, 0);
    idleCycle();
    applyStimulus(1, 0, 0, 9'h000, 1);
    found = 0;
    for (int k = 1; k <= 3 * DIV; k++) begin
      idleCycle();
      if (k == 1) checkVal("busy_after_start", bus.busy, 1);
      if (bus.clken) begin found = k; break; end
    end
    checkVal("first_clken_latency", found, DIV);
    found = 0;
    for (int k = 1; k <= 3 * DIV; k++) begin
      idleCycle();
      if (bus.clken) begin found = k; break; end
    end
    checkVal("clken_spacing", found, DIV);

    // Preset 0x0AA mid-RUN: one-cycle strobe, RUN resumes with a fresh tick phase.
    applyStimulus(0, 0, 1, 9'b010101010, 0);
    idleCycle();
    checkVal("load_endata", bus.endata, 1);
    checkVal("load_data", bus.data, 9'h0AA);
    found = 0;
    for (int k = 1; k <= 3 * DIV; k++) begin
      idleCycle();
      if (k == 1) checkVal("load_strobe_single", {bus.endata, bus.busy}, 2'b01);
      if (bus.clken) begin found = k; break; end
    end
    checkVal("clken_after_load", found, DIV);

    // Count up from 250 into the upper bound.
    applyStimulus(0, 1, 0, 9'h000, 0);
    applyStimulus(0, 0, 1, 9'd250, 0);
    idleCycle();
    applyStimulus(1, 0, 0, 9'h000, 1);
    found = 0;
    for (int k = 1; k <= 12 * DIV; k++) begin
      idleCycle();
      if (bus.at_bound) begin found = 1; break; end
    end
    checkVal("bound_reached", found, 1);
`ifdef UPDOWN_CTRL_PINGPONG_EN
    checkVal("bound_flip", {bus.updown, bus.clken, bus.busy}, 3'b001);
    idleCycle();
    checkVal("bound_pulse_end", {bus.at_bound, bus.busy}, 2'b01);
    applyStimulus(0, 1, 0, 9'h000, 0);
`else
    checkVal("bound_hold", {bus.updown, bus.clken, bus.busy}, 3'b100);
    activity = 0;
    for (int k = 0; k < 2 * DIV; k++) begin
      idleCycle();
      if (bus.clken || bus.busy || !bus.at_bound) activity++;
    end
    checkVal("hold_steady", activity, 0);
    applyStimulus(1, 0, 0, 9'h000, 0);
    idleCycle();
    checkVal("leave_hold", {bus.at_bound, bus.busy, bus.updown}, 3'b010);
    applyStimulus(0, 1, 0, 9'h000, 0);
`endif

    // stop, load_req and start together in RUN: stop wins, nothing follows.
    applyStimulus(0, 0, 1, 9'd100, 0);
    idleCycle();
    applyStimulus(1, 0, 0, 9'h000, 1);
    for (int k = 0; k < 3; k++) idleCycle();
    applyStimulus(1, 1, 1, 9'h033, 0);
    activity = 0;
    for (int k = 0; k < 3 * DIV; k++) begin
      idleCycle();
      if (k == 0) checkVal("stop_wins_busy", bus.busy, 0);
      if (bus.clken || bus.endata) activity++;
    end
    checkVal("no_activity_after_stop", activity, 0);

    // Asynchronous reset in the middle of the LOAD strobe.
    applyStimulus(1, 0, 0, 9'h000, 1);
    idleCycle();
    applyStimulus(0, 0, 1, 9'h055, 0);
    @(posedge clk);
    #2;
    checkVal("endata_before_reset", bus.endata, 1);
    reset = 1'b0;
    #1;
    checkVal("reset_in_load", {18'd0, outVec()}, {18'd0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    bus.start = 0; bus.stop = 0; bus.load_req = 0; bus.load_val = '0; bus.dir_req = 0;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) idleCycle();
    checkVal("idle_after_reset_release", {bus.busy, bus.endata, bus.clken}, 3'b000);

    // Randomized requests, including collisions and out-of-range presets.
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom % 12) == 0, ($urandom % 40) == 0, ($urandom % 25) == 0,
                    9'($urandom), 1'($urandom));
    end
    for (int k = 0; k < 3; k++) idleCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
